// File: rtl/lnl_io_port.sv
// Keyboard/display I/O port: input and output character FIFOs, FGI/FGO flags,
// interrupt enable/request and a sticky overrun flag. LNL_IO_SYNC_EN adds a kbd_strobe synchroniser.

module lnl_io_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_d
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic                    push_ok, pop_ok;

  // A push into a full FIFO is only accepted when an entry leaves in the same cycle.
  always_comb begin
    pop_ok  = pop & (cnt_q != '0);
    push_ok = push & ((cnt_q != CNT_W'(DEPTH)) | pop_ok);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop_ok) rptr_d = rptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  assign head = (cnt_q != '0) ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module lnl_io_port #(
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_strobe,
  input  logic              inp_rd,
  output logic [DATA_W-1:0] inp_data,
  output logic              fgi,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] out_wdata,
  output logic              fgo,
  output logic [DATA_W-1:0] dsp_data,
  output logic              dsp_valid,
  input  logic              dsp_ready,
  input  logic              ien_set,
  input  logic              ien_clr,
  input  logic              int_ack,
  output logic              ien,
  output logic              irq,
  output logic              ovr,
  input  logic              ovr_clr
);
  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic              kbd_push, ovr_set;
  logic              ien_q, ien_d, irq_q, irq_d, ovr_q, ovr_d;

`ifdef LNL_IO_SYNC_EN
  // Two synchroniser flops then one edge-history flop; push on the synchronised rising edge.
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], kbd_strobe};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end
  assign kbd_push = sync_q[1] & ~sync_q[2];
`else
  assign kbd_push = kbd_strobe;
`endif

  lnl_io_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (kbd_push),
    .push_data (kbd_data),
    .pop       (inp_rd),
    .head      (inp_data),
    .cnt_q     (in_cnt_q),
    .cnt_d     (in_cnt_d)
  );

  lnl_io_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_wr),
    .push_data (out_wdata),
    .pop       (dsp_ready),
    .head      (dsp_data),
    .cnt_q     (out_cnt_q),
    .cnt_d     (out_cnt_d)
  );

  assign fgi       = (in_cnt_q != '0);
  assign fgo       = (out_cnt_q != OUT_CW'(OUT_DEPTH));
  assign dsp_valid = (out_cnt_q != '0);

  // Dropped keyboard character: full input FIFO with no accepted pop this cycle.
  assign ovr_set = kbd_push & (in_cnt_q == IN_CW'(IN_DEPTH)) & ~(inp_rd & fgi);

  always_comb begin
    ien_d = ien_q;
    if (ien_set)            ien_d = 1'b1;
    if (ien_clr | int_ack)  ien_d = 1'b0;
    irq_d = ien_d & ((in_cnt_d != '0) | (out_cnt_d != OUT_CW'(OUT_DEPTH)));
    ovr_d = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= irq_d;
      ovr_q <= ovr_d;
    end
  end

  assign ien = ien_q;
  assign irq = irq_q;
  assign ovr = ovr_q;
endmodule

// File: tb/tb_lnl_io_port.sv
// Directed bench for lnl_io_port: reset, input/output FIFOs, overrun, interrupts, optional strobe sync.

module tb_lnl_io_port;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] kbd_data = '0, out_wdata = '0, inp_data, dsp_data;
  logic       kbd_strobe = 0, inp_rd = 0, out_wr = 0, dsp_ready = 0;
  logic       ien_set = 0, ien_clr = 0, int_ack = 0, ovr_clr = 0;
  logic       fgi, fgo, dsp_valid, ien, irq, ovr;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  lnl_io_port dut (
    .clk(clk), .rst_n(rst_n), .kbd_data(kbd_data), .kbd_strobe(kbd_strobe),
    .inp_rd(inp_rd), .inp_data(inp_data), .fgi(fgi), .out_wr(out_wr),
    .out_wdata(out_wdata), .fgo(fgo), .dsp_data(dsp_data), .dsp_valid(dsp_valid),
    .dsp_ready(dsp_ready), .ien_set(ien_set), .ien_clr(ien_clr), .int_ack(int_ack),
    .ien(ien), .irq(irq), .ovr(ovr), .ovr_clr(ovr_clr)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; #3;
    checks++; if (fgi !== 1'b0)       begin errors++; $display("FAIL rst_fgi got=%b exp=0", fgi); end
    checks++; if (fgo !== 1'b1)       begin errors++; $display("FAIL rst_fgo got=%b exp=1", fgo); end
    step(); rst_n = 1; step(); step();
    checks++; if (dsp_valid !== 1'b0) begin errors++; $display("FAIL idle_dsp_valid got=%b exp=0", dsp_valid); end
    checks++; if (irq !== 1'b0)       begin errors++; $display("FAIL idle_irq got=%b exp=0", irq); end
    checks++; if (ovr !== 1'b0)       begin errors++; $display("FAIL idle_ovr got=%b exp=0", ovr); end
    checks++; if (inp_data !== 8'h00) begin errors++; $display("FAIL idle_inp_data got=%h exp=00", inp_data); end
    checks++; if (dsp_data !== 8'h00) begin errors++; $display("FAIL idle_dsp_data got=%h exp=00", dsp_data); end
  endtask

  task automatic test_input_fifo();
    kbd_data = 8'h41; kbd_strobe = 1; step();
    checks++; if (fgi !== 1'b1)       begin errors++; $display("FAIL in_fgi_push1 got=%b exp=1", fgi); end
    kbd_data = 8'h42; step(); kbd_strobe = 0;
    checks++; if (inp_data !== 8'h41) begin errors++; $display("FAIL in_head1 got=%h exp=41", inp_data); end
    inp_rd = 1; step();
    checks++; if (inp_data !== 8'h42) begin errors++; $display("FAIL in_head2 got=%h exp=42", inp_data); end
    checks++; if (fgi !== 1'b1)       begin errors++; $display("FAIL in_fgi_pop1 got=%b exp=1", fgi); end
    step();
    checks++; if (fgi !== 1'b0)       begin errors++; $display("FAIL in_fgi_pop2 got=%b exp=0", fgi); end
    checks++; if (inp_data !== 8'h00) begin errors++; $display("FAIL in_empty_head got=%h exp=00", inp_data); end
    step(); inp_rd = 0;  // read while empty must be harmless
    checks++; if (fgi !== 1'b0)       begin errors++; $display("FAIL in_rd_empty got=%b exp=0", fgi); end
  endtask

  task automatic test_overrun();
    kbd_strobe = 1;
    for (int i = 0; i < 5; i++) begin kbd_data = 8'h50 + 8'(i); step(); end
    kbd_strobe = 0;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", ovr); end
    inp_rd = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (inp_data !== 8'h50 + 8'(i)) begin errors++; $display("FAIL ovr_data%0d got=%h exp=%h", i, inp_data, 8'h50 + 8'(i)); end
      step();
    end
    inp_rd = 0;
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL ovr_drained got=%b exp=0", fgi); end
    ovr_clr = 1; step(); ovr_clr = 0;
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", ovr); end
    kbd_strobe = 1;
    for (int i = 0; i < 4; i++) begin kbd_data = 8'h60 + 8'(i); step(); end
    kbd_data = 8'h64; inp_rd = 1; step(); kbd_strobe = 0;
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_coinc got=%b exp=0", ovr); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (inp_data !== 8'h60 + 8'(i)) begin errors++; $display("FAIL coinc_data%0d got=%h exp=%h", i, inp_data, 8'h60 + 8'(i)); end
      step();
    end
    inp_rd = 0;
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL coinc_drained got=%b exp=0", fgi); end
  endtask

  task automatic test_output_fifo();
    dsp_ready = 0; out_wr = 1;
    for (int i = 0; i < 5; i++) begin
      out_wdata = 8'h30 + 8'(i); step();
      if (i == 3) begin
        checks++; if (fgo !== 1'b0) begin errors++; $display("FAIL out_full got=%b exp=0", fgo); end
      end
    end
    out_wr = 0; dsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h30 + 8'(i)) begin errors++; $display("FAIL dsp_data%0d got=%h/%b exp=%h/1", i, dsp_data, dsp_valid, 8'h30 + 8'(i)); end
      step();
      if (i == 0) begin
        checks++; if (fgo !== 1'b1) begin errors++; $display("FAIL out_fgo_pop1 got=%b exp=1", fgo); end
      end
    end
    checks++; if (dsp_valid !== 1'b0) begin errors++; $display("FAIL out_drained got=%b exp=0", dsp_valid); end
    // empty + push + ready: push only
    out_wdata = 8'h7E; out_wr = 1; step(); out_wr = 0; dsp_ready = 0;
    checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h7E) begin errors++; $display("FAIL out_empty_push got=%h/%b exp=7e/1", dsp_data, dsp_valid); end
    // fill to full, then push + pop together
    out_wr = 1;
    for (int i = 0; i < 3; i++) begin out_wdata = 8'h70 + 8'(i); step(); end
    out_wdata = 8'h73; dsp_ready = 1; step(); out_wr = 0;
    checks++; if (fgo !== 1'b0 || dsp_data !== 8'h70) begin errors++; $display("FAIL out_full_pp got=%b/%h exp=0/70", fgo, dsp_data); end
    for (int i = 0; i < 4; i++) step();
    dsp_ready = 0;
    checks++; if (dsp_valid !== 1'b0) begin errors++; $display("FAIL out_pp_drained got=%b exp=0", dsp_valid); end
  endtask

  task automatic test_interrupt();
    ien_set = 1; step(); ien_set = 0;
    checks++; if (ien !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b/%b exp=1/1", ien, irq); end
    int_ack = 1; step(); int_ack = 0;
    checks++; if (ien !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL irq_ack got=%b/%b exp=0/0", ien, irq); end
    ien_set = 1; ien_clr = 1; step(); ien_set = 0; ien_clr = 0;
    checks++; if (ien !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL ien_setclr got=%b/%b exp=0/0", ien, irq); end
    // fgo=0 and fgi=0: enabled but no request
    out_wr = 1;
    for (int i = 0; i < 4; i++) begin out_wdata = 8'h20; step(); end
    out_wr = 0; ien_set = 1; step(); ien_set = 0;
    checks++; if (ien !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL irq_noflag got=%b/%b exp=1/0", ien, irq); end
    dsp_ready = 1; step(); dsp_ready = 0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_fgo got=%b exp=1", irq); end
    ien_clr = 1; dsp_ready = 1;
    for (int i = 0; i < 3; i++) step();
    ien_clr = 0; dsp_ready = 0;
    checks++; if (irq !== 1'b0 || dsp_valid !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b/%b exp=0/0", irq, dsp_valid); end
  endtask

  task automatic test_sync_strobe();
    kbd_data = 8'h5A; kbd_strobe = 1;
    step(); step();
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL sync_early got=%b exp=0", fgi); end
    step();
    checks++; if (fgi !== 1'b1 || inp_data !== 8'h5A) begin errors++; $display("FAIL sync_push got=%b/%h exp=1/5a", fgi, inp_data); end
    for (int i = 0; i < 7; i++) step();
    kbd_strobe = 0; inp_rd = 1; step(); inp_rd = 0;
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL sync_once got=%b exp=0", fgi); end
  endtask

  task automatic test_reset_mid();
    dsp_ready = 0; out_wr = 1; out_wdata = 8'h11; step(); out_wr = 0;
    rst_n = 0; #2;
    checks++; if (dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin errors++; $display("FAIL rst_mid got=%b/%h exp=0/00", dsp_valid, dsp_data); end
    step(); rst_n = 1; step();
  endtask

  initial begin
    test_reset();
`ifdef LNL_IO_SYNC_EN
    test_sync_strobe();
`else
    test_input_fifo();
    test_overrun();
`endif
    test_output_fifo();
    test_interrupt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
